// File: rtl/nes_mem_pkg.sv
// Shared types and defaults for the NES memory slot scheduler: phase constants,
// FSM and command encodings, and the runtime command priority rule.
package nes_mem_pkg;

  localparam int DEF_PHASES    = 6;
  localparam int DEF_MEM_PHASE = 0;
  localparam int DEF_NES_PHASE = 5;
  localparam int DEF_WAIT_LEN  = 8;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STALL    = 2'd2,
    ST_STEPWAIT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_RD_A = 3'd1,
    CMD_RD_B = 3'd2,
    CMD_WR   = 3'd3,
    CMD_REF  = 3'd4
  } cmd_t;

  // Write beats CPU read beats PPU read; an idle slot is spent on refresh.
  function automatic cmd_t nes_cmd(input logic wr, input logic rd_a, input logic rd_b);
    cmd_t c;
    if (wr) begin
      c = CMD_WR;
    end else if (rd_a) begin
      c = CMD_RD_A;
    end else if (rd_b) begin
      c = CMD_RD_B;
    end else begin
      c = CMD_REF;
    end
    return c;
  endfunction

endpackage

// File: rtl/nes_mem_slot_scheduler_phase_ctr.sv
// Slot phase counter: holds on stall, wraps after PHASES-1, and in step mode
// circulates through the wait phases until a latched step tick releases it.
module nes_phase_ctr
  import nes_mem_pkg::*;
#(
  parameter int PHASES   = DEF_PHASES,
  parameter int WAIT_LEN = DEF_WAIT_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       hold,
  input  logic       step_mode,
  input  logic       step_tick,
  output logic [3:0] phase,
  output logic [3:0] phase_next
);

  localparam logic [3:0] LAST_RUN   = 4'(PHASES - 1);
  localparam logic [3:0] WAIT_FIRST = 4'(PHASES);
  localparam logic [3:0] WAIT_LAST  = 4'(PHASES + WAIT_LEN - 1);

  logic tick_r;
  logic tick_next;
  logic tick_seen;

  assign tick_seen = tick_r | step_tick;

  // Next phase and step-tick latch.
  always_comb begin
    phase_next = phase;
    tick_next  = tick_seen;
    if (clear) begin
      phase_next = 4'd0;
      tick_next  = 1'b0;
    end else if (hold) begin
      phase_next = phase;
    end else if (phase == LAST_RUN) begin
      phase_next = step_mode ? WAIT_FIRST : 4'd0;
    end else if (phase > LAST_RUN) begin
      if (!step_mode) begin
        phase_next = 4'd0;
      end else if (phase != WAIT_LAST) begin
        phase_next = phase + 4'd1;
      end else if (tick_seen) begin
        phase_next = 4'd0;
        tick_next  = 1'b0;
      end else begin
        phase_next = WAIT_FIRST;
      end
    end else begin
      phase_next = phase + 4'd1;
    end
  end

  // Phase and tick registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase  <= 4'd0;
      tick_r <= 1'b0;
    end else begin
      phase  <= phase_next;
      tick_r <= tick_next;
    end
  end

endmodule

// File: rtl/nes_mem_slot_scheduler.sv
// Arbitrates the single MemoryController port between the loader (nes_en=0) and
// the NES core, issuing at most one registered command per NES slot.
module nes_mem_slot_scheduler
  import nes_mem_pkg::*;
#(
  parameter int PHASES    = DEF_PHASES,
  parameter int MEM_PHASE = DEF_MEM_PHASE,
  parameter int NES_PHASE = DEF_NES_PHASE,
  parameter int WAIT_LEN  = DEF_WAIT_LEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nes_en,
  input  logic        step_mode,
  input  logic        step_tick,
  input  logic        ld_write,
  input  logic        ld_refresh,
  input  logic [21:0] ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        cpu_rd,
  input  logic        ppu_rd,
  input  logic        nes_wr,
  input  logic [21:0] nes_addr,
  input  logic [7:0]  nes_dout,
  input  logic        mc_busy,
  output logic        mc_read_a,
  output logic        mc_read_b,
  output logic        mc_write,
  output logic        mc_refresh,
  output logic [21:0] mc_addr,
  output logic [7:0]  mc_din,
  output logic        run_nes,
  output logic [3:0]  phase,
  output logic [15:0] stall_cnt,
  output logic [1:0]  err
);

  localparam logic [3:0] MEM_P      = 4'(MEM_PHASE);
  localparam logic [3:0] NES_P      = 4'(NES_PHASE);
  localparam logic [3:0] WAIT_FIRST = 4'(PHASES);

  state_t      state;
  cmd_t        cmd;
  logic [21:0] cmd_addr;
  logic [7:0]  cmd_din;
  logic [3:0]  phase_next;
  logic        nes_owns;
  logic        stall_now;

  // The LOAD->RUN transition cycle is not yet NES-owned, so phase 0 is seen in full.
  assign nes_owns  = nes_en && (state != ST_LOAD);
  assign stall_now = nes_owns && (phase == MEM_P) && mc_busy;

  nes_phase_ctr #(
    .PHASES   (PHASES),
    .WAIT_LEN (WAIT_LEN)
  ) u_phase_ctr (
    .clk        (clk),
    .reset      (reset),
    .clear      (!nes_owns),
    .hold       (stall_now),
    .step_mode  (step_mode),
    .step_tick  (step_tick),
    .phase      (phase),
    .phase_next (phase_next)
  );

  // Command selection for this cycle.
  always_comb begin
    cmd      = CMD_NONE;
    cmd_addr = nes_addr;
    cmd_din  = nes_dout;
    if (!nes_en) begin
      cmd_addr = ld_addr;
      cmd_din  = ld_data;
      if (ld_write) begin
        cmd = CMD_WR;
      end else if (ld_refresh) begin
        cmd = CMD_REF;
      end else begin
        cmd = CMD_NONE;
      end
    end else if (!nes_owns) begin
      cmd = CMD_NONE;
    end else if ((phase == MEM_P) && !mc_busy) begin
      cmd = nes_cmd(nes_wr, cpu_rd, ppu_rd);
    end else if (phase == WAIT_FIRST) begin
      cmd = CMD_REF;
    end else begin
      cmd = CMD_NONE;
    end
  end

  // FSM with registered command strobes, run enable, stall counter and sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_LOAD;
      mc_read_a  <= 1'b0;
      mc_read_b  <= 1'b0;
      mc_write   <= 1'b0;
      mc_refresh <= 1'b0;
      mc_addr    <= 22'd0;
      mc_din     <= 8'd0;
      run_nes    <= 1'b0;
      stall_cnt  <= 16'd0;
      err        <= 2'b00;
    end else begin
      case (state)
        ST_LOAD: state <= nes_en ? ST_RUN : ST_LOAD;
        ST_RUN, ST_STALL, ST_STEPWAIT: begin
          if (!nes_en) begin
            state <= ST_LOAD;
          end else if (stall_now) begin
            state <= ST_STALL;
          end else if (phase_next >= WAIT_FIRST) begin
            state <= ST_STEPWAIT;
          end else begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_LOAD;
      endcase

      mc_read_a  <= (cmd == CMD_RD_A);
      mc_read_b  <= (cmd == CMD_RD_B);
      mc_write   <= (cmd == CMD_WR);
      mc_refresh <= (cmd == CMD_REF);
      if (cmd != CMD_NONE) begin
        mc_addr <= cmd_addr;
        mc_din  <= cmd_din;
      end
      run_nes <= (phase_next == NES_P);

      if (stall_now && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      err <= err | {nes_en && (ld_write || ld_refresh), cpu_rd && ppu_rd};
    end
  end

endmodule

// File: tb/tb_nes_mem_slot_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// slot-level reference model of the scheduler.
module tb_nes_mem_slot_scheduler;

  localparam int PH   = 6;
  localparam int MEMP = 0;
  localparam int NESP = 5;
  localparam int WL   = 8;

  logic        clk = 1'b0;
  logic        reset, nes_en, step_mode, step_tick, ld_write, ld_refresh;
  logic [21:0] ld_addr, nes_addr;
  logic [7:0]  ld_data, nes_dout;
  logic        cpu_rd, ppu_rd, nes_wr, mc_busy;
  logic        mc_read_a, mc_read_b, mc_write, mc_refresh, run_nes;
  logic [21:0] mc_addr;
  logic [7:0]  mc_din;
  logic [3:0]  phase;
  logic [15:0] stall_cnt;
  logic [1:0]  err;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit          m_owned, m_tick;
  int          m_phase, m_stall;
  logic [1:0]  m_err;
  logic        e_rd_a, e_rd_b, e_wr, e_ref, e_run;
  logic [21:0] e_addr;
  logic [7:0]  e_din;

  nes_mem_slot_scheduler dut (
    .clk(clk), .reset(reset), .nes_en(nes_en), .step_mode(step_mode), .step_tick(step_tick),
    .ld_write(ld_write), .ld_refresh(ld_refresh), .ld_addr(ld_addr), .ld_data(ld_data),
    .cpu_rd(cpu_rd), .ppu_rd(ppu_rd), .nes_wr(nes_wr), .nes_addr(nes_addr), .nes_dout(nes_dout),
    .mc_busy(mc_busy), .mc_read_a(mc_read_a), .mc_read_b(mc_read_b), .mc_write(mc_write),
    .mc_refresh(mc_refresh), .mc_addr(mc_addr), .mc_din(mc_din), .run_nes(run_nes),
    .phase(phase), .stall_cnt(stall_cnt), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [56:0] dut_vec();
    return {mc_read_a, mc_read_b, mc_write, mc_refresh, mc_addr, mc_din, run_nes, phase, stall_cnt, err};
  endfunction

  function automatic logic [56:0] exp_vec();
    return {e_rd_a, e_rd_b, e_wr, e_ref, e_addr, e_din, e_run, 4'(m_phase), 16'(m_stall), m_err};
  endfunction

  function automatic logic [3:0] strobes();
    return {mc_read_a, mc_read_b, mc_write, mc_refresh};
  endfunction

  task automatic drive_idle();
    ld_write = 1'b0; ld_refresh = 1'b0; cpu_rd = 1'b0; ppu_rd = 1'b0;
    nes_wr = 1'b0; mc_busy = 1'b0; step_tick = 1'b0;
  endtask

  // Predict the clock edge from the slot rules, advance one clock, commit the prediction.
  task automatic cycle();
    logic rd_a, rd_b, wr, rf;
    logic [21:0] a;
    logic [7:0] d;
    logic [1:0] ne;
    int np, st;
    bit nt, owns;
    rd_a = 1'b0; rd_b = 1'b0; wr = 1'b0; rf = 1'b0;
    a = e_addr; d = e_din;
    owns = nes_en && m_owned;
    nt = m_tick || step_tick;
    np = 0;
    if (!nes_en) begin
      if (ld_write) wr = 1'b1;
      else if (ld_refresh) rf = 1'b1;
      if (ld_write || ld_refresh) begin a = ld_addr; d = ld_data; end
    end else if (owns) begin
      if (m_phase == MEMP && !mc_busy) begin
        if (nes_wr) wr = 1'b1;
        else if (cpu_rd) rd_a = 1'b1;
        else if (ppu_rd) rd_b = 1'b1;
        else rf = 1'b1;
        a = nes_addr; d = nes_dout;
      end else if (m_phase == PH) begin
        rf = 1'b1; a = nes_addr; d = nes_dout;
      end
    end
    if (!owns) begin np = 0; nt = 1'b0; end
    else if (m_phase == MEMP && mc_busy) np = m_phase;
    else if (m_phase < PH - 1) np = m_phase + 1;
    else if (m_phase == PH - 1) np = step_mode ? PH : 0;
    else if (!step_mode) np = 0;
    else if (m_phase < PH + WL - 1) np = m_phase + 1;
    else if (nt) begin np = 0; nt = 1'b0; end
    else np = PH;
    ne = m_err | {nes_en && (ld_write || ld_refresh), cpu_rd && ppu_rd};
    st = (owns && m_phase == MEMP && mc_busy && m_stall < 65535) ? m_stall + 1 : m_stall;
    @(posedge clk);
    #1;
    if (reset) begin
      e_rd_a = 1'b0; e_rd_b = 1'b0; e_wr = 1'b0; e_ref = 1'b0; e_run = 1'b0;
      e_addr = 22'd0; e_din = 8'd0;
      m_owned = 1'b0; m_tick = 1'b0; m_phase = 0; m_stall = 0; m_err = 2'b00;
    end else begin
      e_rd_a = rd_a; e_rd_b = rd_b; e_wr = wr; e_ref = rf; e_run = (np == NESP);
      e_addr = a; e_din = d;
      m_owned = nes_en; m_tick = nt; m_phase = np; m_stall = st; m_err = ne;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; nes_en = 1'b0; step_mode = 1'b0; drive_idle();
    ld_addr = 22'd0; ld_data = 8'd0; nes_addr = 22'd0; nes_dout = 8'd0;
    cycle(); cycle();
    n_total++;
    if (dut_vec() !== 57'd0) $display("FAIL reset_state: got %h expected 0", dut_vec());
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_load_forward();
    nes_en = 1'b0; ld_write = 1'b1; ld_addr = 22'h000010; ld_data = 8'hA5;
    cycle();
    n_total++;
    if (strobes() !== 4'b0010 || mc_addr !== 22'h000010 || mc_din !== 8'hA5)
      $display("FAIL load_write: strobes %b addr %h din %h expected 0010 000010 a5", strobes(), mc_addr, mc_din);
    else n_pass++;
    ld_refresh = 1'b1; ld_addr = 22'h2AAAAA; ld_data = 8'h3C;
    cycle();
    n_total++;
    if (strobes() !== 4'b0010 || mc_addr !== 22'h2AAAAA)
      $display("FAIL load_write_wins: strobes %b addr %h expected 0010 2aaaaa", strobes(), mc_addr);
    else n_pass++;
    ld_write = 1'b0;
    cycle();
    n_total++;
    if (strobes() !== 4'b0001 || phase !== 4'd0 || run_nes !== 1'b0)
      $display("FAIL load_refresh: strobes %b phase %0d run %b expected 0001 0 0", strobes(), phase, run_nes);
    else n_pass++;
    ld_refresh = 1'b0;
    cycle();
    n_total++;
    if (dut_vec() !== exp_vec()) $display("FAIL load_idle: got %h expected %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_idle_run();
    int nr, nf, bad;
    nr = 0; nf = 0; bad = 0;
    drive_idle(); nes_en = 1'b1;
    cycle();
    n_total++;
    if (phase !== 4'd0 || strobes() !== 4'b0000)
      $display("FAIL run_entry: phase %0d strobes %b expected 0 0000", phase, strobes());
    else n_pass++;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      n_total++;
      if (dut_vec() !== exp_vec()) $display("FAIL idle_model k=%0d: got %h expected %h", k, dut_vec(), exp_vec());
      else n_pass++;
      if (run_nes) nr++;
      if (run_nes && phase !== 4'd5) bad++;
      if (mc_refresh) nf++;
      if (mc_refresh && phase !== 4'd1) bad++;
    end
    n_total++;
    if (nr != 2 || nf != 2 || bad != 0)
      $display("FAIL idle_slots: run_nes %0d refresh %0d misplaced %0d expected 2 2 0", nr, nf, bad);
    else n_pass++;
  endtask

  task automatic test_stall();
    int nra, run_at;
    nra = 0; run_at = -1;
    n_total++;
    if (phase !== 4'd0) $display("FAIL stall_align: phase %0d expected 0", phase);
    else n_pass++;
    cpu_rd = 1'b1; nes_addr = 22'h001234; mc_busy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) mc_busy = 1'b0;
      if (k == 5) cpu_rd = 1'b0;
      cycle();
      n_total++;
      if (dut_vec() !== exp_vec()) $display("FAIL stall_model k=%0d: got %h expected %h", k, dut_vec(), exp_vec());
      else n_pass++;
      if (k <= 3) begin
        n_total++;
        if (phase !== 4'd0 || strobes() !== 4'b0000)
          $display("FAIL stall_hold k=%0d: phase %0d strobes %b expected 0 0000", k, phase, strobes());
        else n_pass++;
      end
      if (mc_read_a) begin
        nra++;
        n_total++;
        if (k != 4 || mc_addr !== 22'h001234)
          $display("FAIL stall_read: at k=%0d addr %h expected k=4 001234", k, mc_addr);
        else n_pass++;
      end
      if (run_nes && run_at < 0) run_at = k;
    end
    n_total++;
    if (stall_cnt !== 16'd3 || nra != 1 || run_at != 8)
      $display("FAIL stall_summary: stall_cnt %0d reads %0d run_at %0d expected 3 1 8", stall_cnt, nra, run_at);
    else n_pass++;
  endtask

  task automatic test_errors();
    drive_idle();
    cycle();
    cpu_rd = 1'b1; ppu_rd = 1'b1; nes_addr = 22'h0000AB;
    cycle();
    n_total++;
    if (strobes() !== 4'b1000 || err !== 2'b01)
      $display("FAIL dual_read: strobes %b err %b expected 1000 01", strobes(), err);
    else n_pass++;
    cpu_rd = 1'b0; ppu_rd = 1'b0;
    ld_write = 1'b1; ld_addr = 22'h155555; ld_data = 8'h77;
    cycle();
    n_total++;
    if (mc_write !== 1'b0 || err !== 2'b11 || dut_vec() !== exp_vec())
      $display("FAIL loader_in_run: write %b err %b expected 0 11", mc_write, err);
    else n_pass++;
    ld_write = 1'b0;
  endtask

  task automatic test_step();
    int nr, nf;
    drive_idle();
    for (int g = 0; g < 20 && phase !== 4'd0; g++) cycle();
    n_total++;
    if (phase !== 4'd0) $display("FAIL step_align: phase %0d expected 0", phase);
    else n_pass++;
    step_mode = 1'b1; nr = 0; nf = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      n_total++;
      if (dut_vec() !== exp_vec()) $display("FAIL step_model k=%0d: got %h expected %h", k, dut_vec(), exp_vec());
      else n_pass++;
      if (run_nes) nr++;
      if (mc_refresh) nf++;
    end
    n_total++;
    if (nr != 1 || nf != 6)
      $display("FAIL step_wait: run_nes %0d refresh %0d expected 1 6", nr, nf);
    else n_pass++;
    step_tick = 1'b1;
    cycle();
    step_tick = 1'b0; nr = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (run_nes) nr++;
    end
    n_total++;
    if (nr != 1) $display("FAIL step_tick: run_nes %0d expected 1", nr);
    else n_pass++;
    n_total++;
    if (phase < 4'd6) $display("FAIL step_in_wait: phase %0d expected >= 6", phase);
    else n_pass++;
    step_mode = 1'b0;
    cycle();
    n_total++;
    if (phase !== 4'd0 || dut_vec() !== exp_vec())
      $display("FAIL step_exit: phase %0d expected 0", phase);
    else n_pass++;
  endtask

  task automatic test_nes_drop();
    drive_idle();
    for (int g = 0; g < 20 && phase !== 4'd3; g++) cycle();
    nes_en = 1'b0; ld_write = 1'b1; ld_addr = 22'h3F0001; ld_data = 8'h5A;
    cycle();
    n_total++;
    if (phase !== 4'd0 || run_nes !== 1'b0 || strobes() !== 4'b0010 || mc_addr !== 22'h3F0001 || mc_din !== 8'h5A)
      $display("FAIL nes_drop: phase %0d run %b strobes %b addr %h din %h expected 0 0 0010 3f0001 5a",
               phase, run_nes, strobes(), mc_addr, mc_din);
    else n_pass++;
    ld_write = 1'b0;
  endtask

  task automatic test_random();
    reset = 1'b1; drive_idle(); nes_en = 1'b0; step_mode = 1'b0;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 63) == 0) nes_en = ~nes_en;
      if ($urandom_range(0, 99) == 0) step_mode = ~step_mode;
      step_tick  = ($urandom_range(0, 19) == 0);
      mc_busy    = ($urandom_range(0, 3) == 0);
      cpu_rd     = ($urandom_range(0, 2) == 0);
      ppu_rd     = ($urandom_range(0, 5) == 0);
      nes_wr     = ($urandom_range(0, 4) == 0);
      ld_write   = nes_en ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 1) == 0);
      ld_refresh = nes_en ? 1'b0 : ($urandom_range(0, 2) == 0);
      ld_addr    = 22'($urandom);
      ld_data    = 8'($urandom);
      nes_addr   = 22'($urandom);
      nes_dout   = 8'($urandom);
      cycle();
      n_total++;
      if (dut_vec() !== exp_vec()) $display("FAIL random k=%0d: got %h expected %h", k, dut_vec(), exp_vec());
      else n_pass++;
      n_total++;
      if ($countones(strobes()) > 1) $display("FAIL one_strobe k=%0d: strobes %b expected at most one", k, strobes());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_load_forward();
    test_idle_run();
    test_stall();
    test_errors();
    test_step();
    test_nes_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
